display_scan_mux: RTL
=====================

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of multiplexed seven-segment digits, legal range 2..16.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clocks per digit slot (1 kHz per slot at 100 MHz), legal value >= 2.
REQ-003 SHALL have port clk  in  1  system clock; one clock domain only.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port value  in  4*N_DIGITS  hex nibbles; nibble i is value[4i+3:4i]; digit 0 is rightmost.
REQ-006 SHALL have port dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit.
REQ-007 SHALL have port digit_en  in  N_DIGITS  per-digit enable, 0 = digit dark.
REQ-008 SHALL have port lz_blank  in  1  leading-zero suppression enable.
REQ-009 SHALL have port anodes  out  N_DIGITS  digit select, active-low, at most one bit low.
REQ-010 SHALL have port segments  out  7  {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp  out  1  decimal point, active-low.
REQ-012 SHALL have port frame_start  out  1  one-cycle pulse on each shadow-register load.

Function
REQ-013 Prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick = (cnt == REFRESH_DIV-1).
REQ-014 Slot index idx ($clog2(N_DIGITS) bits) SHALL advance on each tick: idx = N_DIGITS-1 wraps to 0, else idx+1; idx never holds a value >= N_DIGITS.
REQ-015 Every slot SHALL last exactly REFRESH_DIV cycles; disabled or blanked digits still consume their slot (constant duty cycle).
REQ-016 Shadow registers SHALL capture value, dp_in, digit_en and lz_blank when (tick and idx = N_DIGITS-1) or load_pending = 1; load_pending clears on that load.
REQ-017 Input changes between loads SHALL NOT affect outputs (no tearing within a frame).
REQ-018 frame_start SHALL be 1 in the cycle after each shadow load, else 0.
REQ-019 Digit i SHALL be blanked if shadow digit_en[i] = 0, or if shadow lz_blank = 1, i != 0, and shadow nibbles i..N_DIGITS-1 are all zero; digit 0 is never zero-suppressed.
REQ-020 Blanked slot SHALL drive anodes all 1, segments 7'h7F, dp 1.
REQ-021 Active slot SHALL drive anodes with bit idx = 0 and all others 1, segments = hex glyph of shadow nibble idx, dp = ~shadow dp_in[idx].
REQ-022 anodes, segments and dp SHALL be registered; they reflect a new idx or shadow content one clock after it changes.
REQ-023 Glyphs SHALL be standard hex 0-9, A, b, C, d, E, F (e.g. 0 = 7'b1000000, 1 = 7'b1111001, A = 7'b0001000, F = 7'b0001110).

Reset
REQ-024 While reset = 1, on each clk edge: cnt = 0, idx = 0, shadow registers = 0, load_pending = 1, anodes = all 1, segments = 7'h7F, dp = 1, frame_start = 0.
REQ-025 Reset asserted mid-frame SHALL abort the scan immediately; the scan restarts at idx 0 with a fresh shadow load in the first cycle after release.

Structure
REQ-026 Glyph constants (SEG_BLANK = 7'h7F, per-hex glyph table) SHALL live in shared package display_pkg.
REQ-027 Nibble-to-glyph conversion SHALL be a combinational sub-module hex_to_sseg (4-bit in, 7-bit active-low out).
REQ-028 Prescaler, slot counter, shadow registers, blanking logic and output registers SHALL be in display_scan_mux; no other sub-modules.

Verification (N_DIGITS = 4, REFRESH_DIV = 4)
REQ-029 value = 16'h12AF, digit_en = 4'hF, lz_blank = 0 -> anodes 1110, 1101, 1011, 0111, each held 4 cycles, segments 0001110, 0001000, 0100100, 1111001 in the same order.
REQ-030 value = 16'h0030, lz_blank = 1 -> slots 3 and 2 all anodes 1 and segments 7F; slot 1 = 0110000; slot 0 = 1000000.
REQ-031 digit_en = 4'b0101, dp_in = 4'b0001 -> slots 1 and 3 dark; dp = 0 only in slot 0.
REQ-032 value changed from 16'h1111 to 16'h2222 while idx = 1 -> slots 1..3 still show 1; 2 appears only after the next frame_start pulse.
REQ-033 reset asserted while idx = 2 -> next edge anodes = 1111, segments = 7F, frame_start = 0; one cycle after release frame_start = 1, then scan starts at slot 0.
REQ-034 Continuous run of 3 frames -> exactly one frame_start per 16 cycles; at most one anode bit low at any time.

Source files
------------

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared seven-segment constants for the display blocks.
//   SEG_BLANK  : all segments off (active-low bus, so all ones)
//   HEX_GLYPH  : active-low glyph per hex nibble, bit order {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the glyph for nibble n. Lower-case b and d keep them distinct
  // from 8 and 0.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_to_sseg.sv
// -----------------------------------------------------------------------------
// hex_to_sseg
// Combinational nibble-to-glyph decoder.
//   nibble : 4-bit hex value
//   sseg   : active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_sseg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] sseg
);

  assign sseg = HEX_GLYPH[nibble];

endmodule

// File: rtl/display_scan_mux.sv
// -----------------------------------------------------------------------------
// display_scan_mux
// Time-multiplexed driver for N_DIGITS seven-segment digits. Each digit owns a
// slot of REFRESH_DIV clocks. Inputs are snapshotted into shadow registers
// once per frame, so a frame never shows a mix of old and new content.
//
// Ports
//   clk         : system clock
//   reset       : synchronous, active-high
//   value       : hex nibbles, nibble i = value[4i+3:4i], digit 0 rightmost
//   dp_in       : decimal point request per digit (1 = lit)
//   digit_en    : per-digit enable (0 = dark)
//   lz_blank    : leading-zero suppression enable
//   anodes      : active-low digit select, at most one bit low
//   segments    : active-low {g,f,e,d,c,b,a}
//   dp          : active-low decimal point
//   frame_start : one-cycle pulse in the cycle after each shadow load
// -----------------------------------------------------------------------------
module display_scan_mux
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
  input  logic                    lz_blank,
  output logic [N_DIGITS-1:0]     anodes,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    load_pending;

  logic [4*N_DIGITS-1:0]   sh_value;
  logic [N_DIGITS-1:0]     sh_dp;
  logic [N_DIGITS-1:0]     sh_en;
  logic                    sh_lz;

  logic                    tick;
  logic                    load;
  logic [3:0]              cur_nibble;
  logic                    upper_zero;
  logic                    blank;
  logic [6:0]              glyph;
  logic [N_DIGITS-1:0]     sel_onehot;

  assign tick = (cnt == CNT_LAST);

  // The end-of-frame tick and the post-reset pending flag are the only load
  // points; everything shown comes from the shadow copy.
  assign load = (tick && (idx == IDX_LAST)) || load_pending;

  always_comb begin
    cur_nibble = 4'h0;
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nibble = sh_value[4*i +: 4];
      end
      // Leading-zero test: this digit and every more-significant digit zero.
      if ((IW'(i) >= idx) && (sh_value[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  // Digit 0 is never suppressed so a zero value still shows "0".
  assign blank = !sh_en[idx] || (sh_lz && (idx != '0) && upper_zero);

  assign sel_onehot = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx;

  hex_to_sseg u_hex_to_sseg (
    .nibble (cur_nibble),
    .sseg   (glyph)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      idx          <= '0;
      load_pending <= 1'b1;
      sh_value     <= '0;
      sh_dp        <= '0;
      sh_en        <= '0;
      sh_lz        <= 1'b0;
      anodes       <= '1;
      segments     <= SEG_BLANK;
      dp           <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);

      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end

      if (load) begin
        sh_value     <= value;
        sh_dp        <= dp_in;
        sh_en        <= digit_en;
        sh_lz        <= lz_blank;
        load_pending <= 1'b0;
      end

      frame_start <= load;

      // Outputs are registered from the current idx and shadow content,
      // so they trail a slot change by exactly one clock.
      if (blank) begin
        anodes   <= '1;
        segments <= SEG_BLANK;
        dp       <= 1'b1;
      end else begin
        anodes   <= ~sel_onehot;
        segments <= glyph;
        dp       <= ~sh_dp[idx];
      end
    end
  end

endmodule
